fx_vector_accumulator: RTL and testbench

// Sequencer and accumulator that sits directly upstream and downstream of the scalar
// f(x) core, where f(x) = x/2 + x^2*cos((x-128)/128) in IEEE-754 single precision.
// - Pulls N float samples from a valid/ready stream.
// - Issues each sample to the core with a one-cycle start pulse and holds x until done.
// - Adds every core result into a running FP32 sum using a pipelined fp_add

---
 rtl/fx_vector_accumulator_if.sv | 27 ++
 rtl/fx_vector_accumulator.sv | 275 +++++++++++++++++++++++++++
 tb/tb_fx_vector_accumulator.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx_vector_accumulator_if.sv
// rtl/fx_vector_accumulator_if.sv - sample stream, f(x) core and result signals of the vector accumulator
interface fx_vector_accumulator_if #(
    parameter int N_W = 16
);
    logic           start;
    logic [N_W-1:0] n;
    logic [31:0]    x_data;
    logic           x_valid;
    logic           x_ready;
    logic [31:0]    core_x;
    logic           core_start;
    logic           core_done;
    logic [31:0]    core_result;
    logic [31:0]    result;
    logic           done;

    // master: CPU, sample buffer and f(x) core side; slave: the accumulator
    modport master (
        output start, n, x_data, x_valid, core_done, core_result,
        input  x_ready, core_x, core_start, result, done
    );

    modport slave (
        input  start, n, x_data, x_valid, core_done, core_result,
        output x_ready, core_x, core_start, result, done
    );
endinterface

// File: rtl/fx_vector_accumulator.sv
// rtl/fx_vector_accumulator.sv - sequences samples through the f(x) core and sums results in FP32
module fp_add #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q
);
    // Round-to-nearest-even FP32 add; denormals kept, NaN quieted and passed on.
    function automatic logic [31:0] fp32_add(input logic [31:0] fa, input logic [31:0] fb);
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [23:0] mx;
        logic [23:0] my;
        logic [8:0]  d;
        logic [54:0] t;
        logic [26:0] ys;
        logic [27:0] s;
        logic [26:0] m;
        logic [9:0]  e;
        logic [4:0]  sh;
        logic [30:0] packed_r;
        logic        inc;
        logic        same;
        logic        found;
        fp32_add = 32'h0;
        if (fa[30:23] == 8'hFF || fb[30:23] == 8'hFF) begin
            if (fa[30:23] == 8'hFF && fa[22:0] != 23'h0)
                fp32_add = fa | 32'h0040_0000;
            else if (fb[30:23] == 8'hFF && fb[22:0] != 23'h0)
                fp32_add = fb | 32'h0040_0000;
            else if (fa[30:23] == 8'hFF && fb[30:23] == 8'hFF)
                fp32_add = (fa[31] == fb[31]) ? fa : 32'h7FC0_0000;
            else
                fp32_add = (fa[30:23] == 8'hFF) ? fa : fb;
        end else begin
            if (fa[30:0] < fb[30:0]) begin
                x = fb;
                y = fa;
            end else begin
                x = fa;
                y = fb;
            end
            same = (x[31] == y[31]);
            ex   = (x[30:23] == 8'h0) ? 8'd1 : x[30:23];
            ey   = (y[30:23] == 8'h0) ? 8'd1 : y[30:23];
            mx   = {x[30:23] != 8'h0, x[22:0]};
            my   = {y[30:23] != 8'h0, y[22:0]};
            d    = {1'b0, ex} - {1'b0, ey};
            if (d > 9'd31)
                d = 9'd31;
            // three extra bits below the mantissa: guard, round, sticky
            t  = {my, 31'b0} >> d;
            ys = {t[54:29], t[28] | (|t[27:0])};
            s  = same ? ({1'b0, mx, 3'b000} + {1'b0, ys})
                      : ({1'b0, mx, 3'b000} - {1'b0, ys});
            e  = {2'b00, ex};
            if (s[27]) begin
                m = {s[27:2], s[1] | s[0]};
                e = e + 10'd1;
            end else begin
                m = s[26:0];
            end
            if (m == 27'h0) begin
                fp32_add = same ? {x[31], 31'h0} : 32'h0;
            end else begin
                sh    = 5'd0;
                found = 1'b0;
                for (int i = 26; i >= 0; i--) begin
                    if (!found) begin
                        if (m[i])
                            found = 1'b1;
                        else
                            sh = sh + 5'd1;
                    end
                end
                // never normalise below the minimum exponent; that yields a denormal
                if (10'(sh) >= e)
                    sh = 5'(e - 10'd1);
                m = m << sh;
                e = e - 10'(sh);
                if (!m[26])
                    e = 10'd0;
                if (e >= 10'd255) begin
                    fp32_add = {x[31], 8'hFF, 23'h0};
                end else begin
                    inc      = m[2] & (m[1] | m[0] | m[3]);
                    packed_r = {e[7:0], m[25:3]} + {30'h0, inc};
                    fp32_add = {x[31], packed_r};
                end
            end
        end
    endfunction

    logic [31:0] sum_c;
    logic [31:0] pipe [LAT];

    assign sum_c = fp32_add(a, b);

    always_ff @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < LAT; i++)
                pipe[i] <= 32'h0;
        end else if (en) begin
            pipe[0] <= sum_c;
            for (int i = 1; i < LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[LAT-1];
endmodule

module fx_vector_accumulator #(
    parameter int ADD_LAT = 3,
    parameter int N_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    fx_vector_accumulator_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ACC,
        S_FIN
    } state_t;

    localparam int CW = $clog2(ADD_LAT + 2);

    state_t         state;
    state_t         state_nxt;
    logic [N_W-1:0] remaining;
    logic [31:0]    acc;
    logic [31:0]    core_x;
    logic [31:0]    res_hold;
    logic [31:0]    result;
    logic [31:0]    sum_q;
    logic           core_start;
    logic           done;
    logic [CW-1:0]  add_cnt;

    logic clear;
    logic ready_c;
    logic run_start;
    logic accept;
    logic capture;
    logic retire;
    logic add_en;
    logic fin;

    // clk_en low behaves exactly like reset
    assign clear = reset | ~clk_en;

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        run_start = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        retire    = 1'b0;
        add_en    = 1'b0;
        fin       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    run_start = 1'b1;
                    state_nxt = (bus.n == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                ready_c = 1'b1;
                if (bus.x_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    capture   = 1'b1;
                    state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                add_en = 1'b1;
                if (add_cnt == CW'(ADD_LAT)) begin
                    retire    = 1'b1;
                    state_nxt = (remaining <= N_W'(1)) ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                fin       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // an aborted cycle must not consume the upstream handshake
        if (clear) begin
            state_nxt = S_IDLE;
            ready_c   = 1'b0;
            run_start = 1'b0;
            accept    = 1'b0;
            capture   = 1'b0;
            retire    = 1'b0;
            add_en    = 1'b0;
            fin       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            remaining  <= '0;
            acc        <= 32'h0;
            core_x     <= 32'h0;
            res_hold   <= 32'h0;
            result     <= 32'h0;
            core_start <= 1'b0;
            done       <= 1'b0;
            add_cnt    <= '0;
        end else begin
            core_start <= accept;
            done       <= fin;
            if (run_start) begin
                remaining <= bus.n;
                acc       <= 32'h0;
            end
            if (accept)
                core_x <= bus.x_data;
            if (capture) begin
                res_hold <= bus.core_result;
                add_cnt  <= '0;
            end else if (add_en) begin
                add_cnt <= add_cnt + CW'(1);
            end
            if (retire) begin
                acc       <= sum_q;
                remaining <= (remaining != '0) ? remaining - N_W'(1) : '0;
            end
            if (fin)
                result <= acc;
        end
    end

    // operands stay stable through ACC, so after ADD_LAT enabled cycles q is acc + res_hold
    fp_add #(
        .LAT (ADD_LAT)
    ) u_fp_add (
        .clk    (clk),
        .areset (reset),
        .en     (add_en),
        .a      (acc),
        .b      (res_hold),
        .q      (sum_q)
    );

    assign bus.x_ready    = ready_c;
    assign bus.core_x     = core_x;
    assign bus.core_start = core_start;
    assign bus.result     = result;
    assign bus.done       = done;
endmodule

// File: tb/tb_fx_vector_accumulator.sv
// tb/tb_fx_vector_accumulator.sv - directed and randomised runs against an FP32 reference sum
module tb_fx_vector_accumulator;
    localparam int ADD_LAT  = 3;
    localparam int N_W      = 16;
    localparam int CORE_LAT = 3;
    localparam int BOUND    = 2000;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;

    always #5 clk = ~clk;

    fx_vector_accumulator_if #(.N_W(N_W)) acc_bus ();

    fx_vector_accumulator #(
        .ADD_LAT (ADD_LAT),
        .N_W     (N_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (acc_bus.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic        run_start = 1'b0;
    logic        inj_start = 1'b0;
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [31:0] model_res = 32'h0;
    logic        busy = 1'b0;
    int          lat_cnt = 0;
    int          post_done = 0;
    bit          inject_on = 1'b0;
    logic [31:0] x_hold = 32'h0;
    int          starts_seen = 0;
    int          dones_seen = 0;
    int          ready_cycles = 0;
    logic [31:0] xs[$];
    int          gaps[$];
    logic [31:0] exp_x[$];

    assign acc_bus.start       = run_start | inj_start;
    assign acc_bus.core_done   = model_done | spur_done;
    assign acc_bus.core_result = model_done ? model_res : 32'h7F80_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e11;
        if (f[30:0] == 31'h0)
            return 0.0;
        e11 = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e11, f[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] m25;
        logic [7:0]  e8;
        logic        inc;
        d = $realtobits(r);
        if (d[62:0] == 63'h0)
            return {d[63], 31'h0};
        e8  = 8'(d[62:52] - 11'd896);
        inc = d[28] & ((|d[27:0]) | d[29]);
        m25 = {2'b01, d[51:29]} + {24'h0, inc};
        if (m25[24]) begin
            e8 = e8 + 8'd1;
            return {d[63], e8, 23'h0};
        end
        return {d[63], e8, m25[22:0]};
    endfunction

    function automatic logic [31:0] fx_model(input logic [31:0] x);
        real v;
        v = f2r(x);
        return r2f(v / 2.0 + v * v * $cos((v - 128.0) / 128.0));
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    always @(negedge clk) begin
        if (acc_bus.x_ready)
            ready_cycles++;
        if (acc_bus.done)
            dones_seen++;
        if (acc_bus.core_start)
            starts_seen++;
    end

    // f(x) core model: answers CORE_LAT cycles after core_start
    always @(negedge clk) begin
        model_done = 1'b0;
        if (post_done > 0)
            post_done--;
        if (reset || !clk_en) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                if (lat_cnt == 0) begin
                    check("core_x_held", acc_bus.core_x, x_hold);
                    model_res  = fx_model(x_hold);
                    model_done = 1'b1;
                    busy       = 1'b0;
                    post_done  = 3;
                end else begin
                    lat_cnt--;
                end
            end
            if (acc_bus.core_start) begin
                if (exp_x.size() == 0)
                    check("core_start_unexpected", 32'(exp_x.size()), 32'd1);
                else
                    check("core_x_sample", acc_bus.core_x, exp_x.pop_front());
                busy    = 1'b1;
                x_hold  = acc_bus.core_x;
                lat_cnt = CORE_LAT - 1;
            end
        end
    end

    always @(negedge clk) begin
        inj_start = 1'b0;
        spur_done = 1'b0;
        if (inject_on) begin
            if ((acc_bus.x_ready || busy || post_done > 0) && $urandom_range(0, 2) == 0)
                inj_start = 1'b1;
            if (acc_bus.x_ready && $urandom_range(0, 2) == 0)
                spur_done = 1'b1;
        end
    end

    task automatic pulse_start(input int cnt);
        acc_bus.n = N_W'(cnt);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!acc_bus.x_ready && w < BOUND) begin
            @(negedge clk);
            w++;
        end
        if (!acc_bus.x_ready)
            check("x_ready_timeout", {31'h0, acc_bus.x_ready}, 32'd1);
    endtask

    task automatic run_samples(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            wait_ready();
            repeat (gaps[i]) @(negedge clk);
            acc_bus.x_data  = xs[i];
            acc_bus.x_valid = 1'b1;
            exp_x.push_back(xs[i]);
            @(negedge clk);
            acc_bus.x_valid = 1'b0;
            acc_bus.x_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_run(input int cnt, input string tag);
        logic [31:0] exp_sum = 32'h0;
        int s0, d0, r0, w;
        int gsum = 0;
        for (int i = 0; i < cnt; i++) begin
            exp_sum = ref_add(exp_sum, fx_model(xs[i]));
            gsum += gaps[i];
        end
        s0 = starts_seen;
        d0 = dones_seen;
        r0 = ready_cycles;
        pulse_start(cnt);
        run_samples(cnt);
        w = 0;
        while (dones_seen == d0 && w < BOUND) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_result"}, acc_bus.result, exp_sum);
        check({tag, "_done_pulses"}, 32'(dones_seen - d0), 32'd1);
        check({tag, "_core_starts"}, 32'(starts_seen - s0), 32'(cnt));
        check({tag, "_ready_cycles"}, 32'(ready_cycles - r0), 32'(cnt + gsum));
    endtask

    task automatic set_random(input int cnt, input int gmax);
        xs.delete();
        gaps.delete();
        for (int i = 0; i < cnt; i++) begin
            xs.push_back(r2f(real'($urandom_range(0, 255))));
            gaps.push_back(int'($urandom_range(0, gmax)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s0, d0, r0;
        reset           = 1'b1;
        clk_en          = 1'b1;
        acc_bus.n       = '0;
        acc_bus.x_data  = 32'h0;
        acc_bus.x_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x_ready", {31'h0, acc_bus.x_ready}, 32'd0);
        check("rst_core_start", {31'h0, acc_bus.core_start}, 32'd0);
        check("rst_done", {31'h0, acc_bus.done}, 32'd0);
        check("rst_result", acc_bus.result, 32'h0);
        check("rst_core_x", acc_bus.core_x, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // single sample of 128.0
        xs   = '{32'h4300_0000};
        gaps = '{0};
        do_run(1, "t1");
        check("t1_hand", acc_bus.result, 32'h4680_8000);
        repeat (10) @(negedge clk);
        check("t1_hold", acc_bus.result, 32'h4680_8000);

        // two samples with a 5-cycle valid gap
        xs   = '{32'h4300_0000, 32'h4300_0000};
        gaps = '{0, 5};
        do_run(2, "t2");
        check("t2_hand", acc_bus.result, 32'h4700_8000);

        // n == 0
        s0 = starts_seen;
        r0 = ready_cycles;
        pulse_start(0);
        check("t3_done_in_fin", {31'h0, acc_bus.done}, 32'd0);
        @(negedge clk);
        check("t3_done", {31'h0, acc_bus.done}, 32'd1);
        check("t3_result", acc_bus.result, 32'h0);
        @(negedge clk);
        check("t3_done_single", {31'h0, acc_bus.done}, 32'd0);
        check("t3_core_starts", 32'(starts_seen - s0), 32'd0);
        check("t3_ready_cycles", 32'(ready_cycles - r0), 32'd0);

        // reset during the second WAIT of an n=3 run
        check("t4_pre_result", acc_bus.result, 32'h0);
        xs   = '{32'h4120_0000, 32'h41A0_0000, 32'h41F0_0000};
        gaps = '{0, 0, 0};
        d0   = dones_seen;
        pulse_start(3);
        run_samples(2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t4_x_ready", {31'h0, acc_bus.x_ready}, 32'd0);
        check("t4_result", acc_bus.result, 32'h0);
        check("t4_core_start", {31'h0, acc_bus.core_start}, 32'd0);
        reset = 1'b0;
        s0    = starts_seen;
        repeat (10) @(negedge clk);
        check("t4_no_done", 32'(dones_seen - d0), 32'd0);
        check("t4_idle_no_start", 32'(starts_seen - s0), 32'd0);
        exp_x.delete();
        xs   = '{32'h0};
        gaps = '{0};
        do_run(1, "t4_rerun");
        check("t4_rerun_hand", acc_bus.result, 32'h0);

        // clk_en drop while a sample is offered: handshake not consumed
        d0 = dones_seen;
        s0 = starts_seen;
        pulse_start(2);
        wait_ready();
        acc_bus.x_data  = 32'h4300_0000;
        acc_bus.x_valid = 1'b1;
        clk_en          = 1'b0;
        @(negedge clk);
        check("t4b_x_ready", {31'h0, acc_bus.x_ready}, 32'd0);
        acc_bus.x_valid = 1'b0;
        clk_en          = 1'b1;
        repeat (8) @(negedge clk);
        check("t4b_core_starts", 32'(starts_seen - s0), 32'd0);
        check("t4b_no_done", 32'(dones_seen - d0), 32'd0);
        check("t4b_result", acc_bus.result, 32'h0);
        check("t4b_idle", {31'h0, acc_bus.x_ready}, 32'd0);

        // spurious start and core_done while busy
        set_random(8, 3);
        inject_on = 1'b1;
        do_run(8, "t5");
        inject_on = 1'b0;
        repeat (3) @(negedge clk);

        // random runs
        for (int r = 0; r < 3; r++) begin
            set_random(int'($urandom_range(1, 64)), 3);
            do_run(xs.size(), $sformatf("t6_run%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
